multicycle_control_hs: RTL

- Next-generation multi-cycle RV32I control unit. Drives the shared-memory datapath (PC, IR, MDR, A/B, ALUOut) through one Moore FSM.
- Replaces fixed single-cycle memory access with a request/ready handshake, and adds a parametrised wait-timeout trap.
- Adds illegal-opcode detection, a sticky ECALL halt, and retired-instruction and cycle counters.
- Sits between the IR opcode field and all datapath mux and enable controls.

---
 rtl/multicycle_control_hs.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control_hs.sv
// Multi-cycle RV32I control FSM with a memory request/ready handshake,
// wait-timeout bus-error trap, illegal-opcode trap, ECALL halt and counters.
module multicycle_control_hs #(
  parameter int CNT_WIDTH  = 32,
  parameter int MAX_WAIT   = 15,
  parameter int WAIT_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           part_of_inst,
  input  logic                 alu_bcond,
  input  logic                 halt_req,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 i_or_d,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 pc_source,
  output logic                 alu_src_A,
  output logic [1:0]           alu_src_B,
  output logic [1:0]           ALUOp,
  output logic                 reg_write,
  output logic                 mem_to_reg,
  output logic                 retire,
  output logic                 halted,
  output logic                 trap,
  output logic [1:0]           trap_cause,
  output logic [CNT_WIDTH-1:0] instret,
  output logic [CNT_WIDTH-1:0] cycles
);
  localparam logic [6:0] OP_ARITH     = 7'b0110011;
  localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
  localparam logic [6:0] OP_LOAD      = 7'b0000011;
  localparam logic [6:0] OP_STORE     = 7'b0100011;
  localparam logic [6:0] OP_BRANCH    = 7'b1100011;
  localparam logic [6:0] OP_JAL       = 7'b1101111;
  localparam logic [6:0] OP_JALR      = 7'b1100111;
  localparam logic [6:0] OP_ECALL     = 7'b1110011;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_BUS     = 2'b10;

  typedef enum logic [4:0] {
    S_IF, S_ID, S_MEM_ADDR, S_LD_WAIT, S_WB_LD, S_ST_WAIT, S_EX_R, S_EX_I,
    S_WB_ALU, S_BR, S_BR_T, S_JAL, S_JALR, S_ECALL, S_HALT, S_TRAP
  } state_t;

  state_t                state, state_n;
  logic [WAIT_WIDTH-1:0] wait_cnt;
  logic [1:0]            cause_n;
  logic                  in_wait, timeout;

  assign in_wait = (state == S_IF) || (state == S_LD_WAIT) || (state == S_ST_WAIT);
  // mem_ready on the limit cycle still completes the access
  assign timeout = in_wait && !mem_ready && (wait_cnt == WAIT_WIDTH'(MAX_WAIT));

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IF;
      wait_cnt   <= '0;
      instret    <= '0;
      cycles     <= '0;
      halted     <= 1'b0;
      trap       <= 1'b0;
      trap_cause <= 2'b00;
    end else begin
      state <= state_n;
      if (state_n != state)
        wait_cnt <= '0;
      else if (in_wait && !mem_ready)
        wait_cnt <= wait_cnt + 1'b1;
      if (retire)
        instret <= instret + CNT_WIDTH'(1);
      if (!halted && !trap)
        cycles <= cycles + CNT_WIDTH'(1);
      if (state_n == S_HALT)
        halted <= 1'b1;
      if (state_n == S_TRAP && state != S_TRAP) begin
        trap       <= 1'b1;
        trap_cause <= cause_n;
      end
    end
  end

  always_comb begin
    state_n    = state;
    cause_n    = 2'b00;
    mem_req    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    i_or_d     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_source  = 1'b0;
    alu_src_A  = 1'b0;
    alu_src_B  = 2'b00;
    ALUOp      = 2'b00;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    retire     = 1'b0;
    unique case (state)
      S_IF: begin
        mem_req  = 1'b1;
        mem_read = 1'b1;
        ir_write = mem_ready;
        if (mem_ready) state_n = S_ID;
        else if (timeout) begin state_n = S_TRAP; cause_n = CAUSE_BUS; end
      end
      S_ID: begin
        alu_src_B = 2'b01;
        unique case (part_of_inst)
          OP_ARITH:           state_n = S_EX_R;
          OP_ARITH_IMM:       state_n = S_EX_I;
          OP_LOAD, OP_STORE:  state_n = S_MEM_ADDR;
          OP_BRANCH:          state_n = S_BR;
          OP_JAL:             state_n = S_JAL;
          OP_JALR:            state_n = S_JALR;
          OP_ECALL:           state_n = S_ECALL;
          default: begin state_n = S_TRAP; cause_n = CAUSE_ILLEGAL; end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_A = 1'b1;
        alu_src_B = 2'b10;
        state_n   = (part_of_inst == OP_STORE) ? S_ST_WAIT : S_LD_WAIT;
      end
      S_LD_WAIT: begin
        mem_req  = 1'b1;
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) state_n = S_WB_LD;
        else if (timeout) begin state_n = S_TRAP; cause_n = CAUSE_BUS; end
      end
      S_WB_LD: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        alu_src_B  = 2'b01;
        pc_write   = 1'b1;
        retire     = 1'b1;
        state_n    = S_IF;
      end
      S_ST_WAIT: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        alu_src_B = 2'b01;
        pc_write  = mem_ready;
        retire    = mem_ready;
        if (mem_ready) state_n = S_IF;
        else if (timeout) begin state_n = S_TRAP; cause_n = CAUSE_BUS; end
      end
      S_EX_R: begin
        alu_src_A = 1'b1;
        ALUOp     = 2'b10;
        state_n   = S_WB_ALU;
      end
      S_EX_I: begin
        alu_src_A = 1'b1;
        alu_src_B = 2'b10;
        ALUOp     = 2'b10;
        state_n   = S_WB_ALU;
      end
      S_WB_ALU: begin
        reg_write = 1'b1;
        alu_src_B = 2'b01;
        pc_write  = 1'b1;
        retire    = 1'b1;
        state_n   = S_IF;
      end
      S_BR: begin
        alu_src_A = 1'b1;
        ALUOp     = 2'b01;
        pc_source = 1'b1;
        // not taken: ALUOut still holds PC+4 from ID
        pc_write  = !alu_bcond;
        retire    = !alu_bcond;
        state_n   = alu_bcond ? S_BR_T : S_IF;
      end
      S_BR_T: begin
        alu_src_B = 2'b10;
        pc_write  = 1'b1;
        retire    = 1'b1;
        state_n   = S_IF;
      end
      S_JAL: begin
        reg_write = 1'b1;
        alu_src_B = 2'b10;
        pc_write  = 1'b1;
        retire    = 1'b1;
        state_n   = S_IF;
      end
      S_JALR: begin
        reg_write = 1'b1;
        alu_src_A = 1'b1;
        alu_src_B = 2'b10;
        pc_write  = 1'b1;
        retire    = 1'b1;
        state_n   = S_IF;
      end
      S_ECALL: begin
        retire = 1'b1;
        if (halt_req) state_n = S_HALT;
        else begin
          alu_src_B = 2'b01;
          pc_write  = 1'b1;
          state_n   = S_IF;
        end
      end
      S_HALT:  state_n = S_HALT;
      S_TRAP:  state_n = S_TRAP;
      default: state_n = S_IF;
    endcase
  end
endmodule
